// File: rtl/axibram_rd_stream_dev_pkg.sv
// Shared constants for the memory-side read device: region decode and the
// layout of internal status word 0.
package axibram_rd_stream_dev_pkg;

   localparam int unsigned DATA_W           = 32;
   localparam int unsigned STATUS0_IDX      = 0;
   localparam int unsigned STATUS0_OVF_BIT  = 31;
   localparam int unsigned STATUS0_FILL_LSB = 0;

   // The top word-address bit selects the stream window over the status window.
   function automatic int unsigned region_bit(input int unsigned address_bits);
      return address_bits - 1;
   endfunction

endpackage

// File: rtl/axibram_rd_stream_dev_fifo.sv
// Single-clock show-ahead FIFO; the caller guarantees no push when full
// (unless popping the same cycle) and no pop when empty.
module fifo_same_clock #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DATA_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  nempty,
   output logic                  full
);

   localparam int unsigned DEPTH = 1 << DATA_DEPTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_DEPTH:0]   wr_ptr;
   logic [DATA_DEPTH:0]   rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign nempty   = (wr_ptr != rd_ptr);
   assign full     = (wr_ptr[DATA_DEPTH] != rd_ptr[DATA_DEPTH]) &&
                     (wr_ptr[DATA_DEPTH-1:0] == rd_ptr[DATA_DEPTH-1:0]);
   assign data_out = mem[rd_ptr[DATA_DEPTH-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (we) wr_ptr <= wr_ptr + (DATA_DEPTH+1)'(1);
         if (re) rd_ptr <= rd_ptr + (DATA_DEPTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr[DATA_DEPTH-1:0]] <= data_in;
   end

endmodule

// File: rtl/axibram_rd_stream_dev.sv
// Read-side memory device behind the AXI read bridge: a live status window and
// a streaming window that pops a FIFO fed by a producer without backpressure.
module axibram_rd_stream_dev
   import axibram_rd_stream_dev_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS      = 10,
   parameter int unsigned FIFO_DEPTH_LOG2   = 4,
   parameter int unsigned STATUS_WORDS_LOG2 = 3
) (
   input  logic                                      aclk,
   input  logic                                      rst,
   input  logic [ADDRESS_BITS-1:0]                   pre_araddr,
   input  logic                                      start_burst,
   output logic                                      dev_ready,
   input  logic [ADDRESS_BITS-1:0]                   bram_raddr,
   input  logic                                      bram_ren,
   input  logic                                      bram_regen,
   output logic [31:0]                               bram_rdata,
   input  logic [31:0]                               s_data,
   input  logic                                      s_we,
   input  logic [32*(2**STATUS_WORDS_LOG2)-1:0]      status_in,
   output logic [FIFO_DEPTH_LOG2:0]                  fifo_fill,
   output logic                                      overflow
);

   localparam int unsigned FILL_W  = FIFO_DEPTH_LOG2 + 1;
   localparam int unsigned SEL_BIT = region_bit(ADDRESS_BITS);

   logic                         sel_stream_r;
   logic [DATA_W-1:0]            stage1;
   logic [DATA_W-1:0]            fifo_head;
   logic                         fifo_nempty;
   logic                         fifo_full;
   logic                         pop;
   logic                         push;
   logic                         ovf_event;
   logic                         ovf_clear;
   logic [STATUS_WORDS_LOG2-1:0] status_idx;
   logic [DATA_W-1:0]            status0;
   logic [DATA_W-1:0]            selected;
   logic                         unused_bits;

   // Registered-only path: start_burst depends on this, so no input may feed it.
   assign dev_ready = sel_stream_r ? fifo_nempty : 1'b1;

   assign pop        = bram_ren & sel_stream_r & fifo_nempty;
   assign push       = s_we & (~fifo_full | pop);
   assign ovf_event  = s_we & fifo_full & ~pop;
   assign status_idx = bram_raddr[STATUS_WORDS_LOG2-1:0];
   assign ovf_clear  = bram_ren & ~sel_stream_r &
                       (status_idx == STATUS_WORDS_LOG2'(STATUS0_IDX));

   assign unused_bits = ^{pre_araddr[SEL_BIT-1:0],
                          bram_raddr[ADDRESS_BITS-1:STATUS_WORDS_LOG2],
                          status_in[DATA_W-1:0]};

   always_comb begin
      status0 = '0;
      status0[STATUS0_FILL_LSB +: FILL_W] = fifo_fill;
      status0[STATUS0_OVF_BIT]            = overflow;
   end

   // Stream beats take the FIFO head (0 if popped while empty); status beats index the window.
   always_comb begin
      selected = '0;
      if (sel_stream_r) begin
         if (fifo_nempty) selected = fifo_head;
      end else if (status_idx == STATUS_WORDS_LOG2'(STATUS0_IDX)) begin
         selected = status0;
      end else begin
         selected = status_in[{status_idx, 5'b00000} +: DATA_W];
      end
   end

   fifo_same_clock #(
      .DATA_WIDTH (DATA_W),
      .DATA_DEPTH (FIFO_DEPTH_LOG2)
   ) i_fifo (
      .clk      (aclk),
      .rst      (rst),
      .we       (push),
      .re       (pop),
      .data_in  (s_data),
      .data_out (fifo_head),
      .nempty   (fifo_nempty),
      .full     (fifo_full)
   );

   always_ff @(posedge aclk) begin
      if (rst) begin
         sel_stream_r <= 1'b0;
         stage1       <= '0;
         bram_rdata   <= '0;
         fifo_fill    <= '0;
         overflow     <= 1'b0;
      end else begin
         if (start_burst) sel_stream_r <= pre_araddr[SEL_BIT];
         if (bram_ren)    stage1       <= selected;
         if (bram_regen)  bram_rdata   <= stage1;
         if (push && !pop)      fifo_fill <= fifo_fill + FILL_W'(1);
         else if (pop && !push) fifo_fill <= fifo_fill - FILL_W'(1);
         // A drop in the same cycle as the clearing read keeps the flag set.
         if (ovf_event)      overflow <= 1'b1;
         else if (ovf_clear) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axibram_rd_stream_dev.sv
// Bench for axibram_rd_stream_dev: queue-based reference model checked every
// cycle, plus directed bursts with literal expected read data.
module tb_axibram_rd_stream_dev;

   localparam int AB    = 10;
   localparam int FL    = 4;
   localparam int SL    = 3;
   localparam int DEPTH = 16;

   logic          aclk = 1'b0;
   logic          rst;
   logic [AB-1:0] pre_araddr;
   logic          start_burst;
   logic          dev_ready;
   logic [AB-1:0] bram_raddr;
   logic          bram_ren;
   logic          bram_regen;
   logic [31:0]   bram_rdata;
   logic [31:0]   s_data;
   logic          s_we;
   logic [255:0]  status_in;
   logic [FL:0]   fifo_fill;
   logic          overflow;

   int vectors     = 0;
   int miscompares = 0;

   always #5 aclk = ~aclk;

   axibram_rd_stream_dev #(
      .ADDRESS_BITS      (AB),
      .FIFO_DEPTH_LOG2   (FL),
      .STATUS_WORDS_LOG2 (SL)
   ) dut (
      .aclk        (aclk),
      .rst         (rst),
      .pre_araddr  (pre_araddr),
      .start_burst (start_burst),
      .dev_ready   (dev_ready),
      .bram_raddr  (bram_raddr),
      .bram_ren    (bram_ren),
      .bram_regen  (bram_regen),
      .bram_rdata  (bram_rdata),
      .s_data      (s_data),
      .s_we        (s_we),
      .status_in   (status_in),
      .fifo_fill   (fifo_fill),
      .overflow    (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue, sticky flag, two pipeline words.
   logic [31:0] mq[$];
   logic        m_ovf = 1'b0;
   logic        m_sel = 1'b0;
   logic [31:0] m_st1 = '0;
   logic [31:0] m_rd  = '0;
   bit          m_valid = 1'b0;

   always @(posedge aclk) begin : model
      int          n;
      bit          pop_m, ovf_ev, clr;
      logic [31:0] w;
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0; m_sel = 1'b0; m_st1 = '0; m_rd = '0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         n     = mq.size();
         pop_m = bram_ren && m_sel && n > 0;
         if (bram_regen) m_rd = m_st1;
         if (bram_ren) begin
            if (m_sel)                    w = (n > 0) ? mq[0] : 32'h0;
            else if (bram_raddr[2:0] == 0) w = {m_ovf, 26'd0, 5'(n)};
            else                          w = status_in[bram_raddr[2:0]*32 +: 32];
            m_st1 = w;
         end
         clr    = bram_ren && !m_sel && bram_raddr[2:0] == 0;
         ovf_ev = 1'b0;
         if (pop_m) void'(mq.pop_front());
         if (s_we) begin
            if (n < DEPTH || pop_m) mq.push_back(s_data);
            else                    ovf_ev = 1'b1;
         end
         if (ovf_ev)   m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (start_burst) m_sel = pre_araddr[AB-1];
      end
   end

   always @(negedge aclk) begin
      if (m_valid) begin
         check("fifo_fill", 32'(fifo_fill), 32'(mq.size()));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("bram_rdata", bram_rdata, m_rd);
         check("dev_ready", 32'(dev_ready), (!m_sel || mq.size() != 0) ? 32'd1 : 32'd0);
      end
   end

   // Collect the word that lands in bram_rdata one edge after each read beat.
   logic [31:0] cap[$];
   bit          ren_prev = 1'b0;
   always @(posedge aclk) begin : capture
      bit take;
      take     = ren_prev && bram_regen && !rst;
      ren_prev = bram_ren && !rst;
      if (take) begin
         #1;
         cap.push_back(bram_rdata);
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] d);
      s_we = 1'b1; s_data = d;
      tick();
      s_we = 1'b0;
   endtask

   task automatic burst(input logic [AB-1:0] addr, input int len,
                        input bit push_first, input logic [31:0] pdata);
      int waited;
      pre_araddr = addr; start_burst = 1'b1;
      tick();
      start_burst = 1'b0;
      for (int i = 0; i <= len; i++) begin
         waited = 0;
         while (!dev_ready && waited < 200) begin
            tick();
            waited++;
         end
         if (!dev_ready) begin
            check("ready_timeout", 32'(dev_ready), 32'd1);
            return;
         end
         bram_raddr = addr + AB'(i);
         bram_ren   = 1'b1;
         if (push_first && i == 0) begin
            s_we = 1'b1; s_data = pdata;
         end
         tick();
         bram_ren = 1'b0;
         if (push_first && i == 0) s_we = 1'b0;
      end
      tick();
      tick();
   endtask

   task automatic check_cap(input string name, input int idx, input logic [31:0] exp);
      if (idx < cap.size()) check(name, cap[idx], exp);
      else                  check({name, "_missing"}, 32'(cap.size()), 32'(idx + 1));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p_we;
      rst = 1'b1; pre_araddr = '0; start_burst = 1'b0; bram_raddr = '0;
      bram_ren = 1'b0; bram_regen = 1'b1; s_data = '0; s_we = 1'b0;
      for (int k = 0; k < 8; k++) status_in[k*32 +: 32] = 32'hA0 + 32'(k);
      tick(); tick();
      check("reset_fill", 32'(fifo_fill), 32'd0);
      check("reset_rdata", bram_rdata, 32'd0);
      check("reset_ready", 32'(dev_ready), 32'd1);
      rst = 1'b0;
      tick();

      // Status burst at word 2, three beats.
      cap.delete();
      burst(10'h002, 2, 1'b0, '0);
      check_cap("status_w2", 0, 32'hA2);
      check_cap("status_w3", 1, 32'hA3);
      check_cap("status_w4", 2, 32'hA4);

      // Three stream words drained by a three-beat burst.
      cap.delete();
      push_word(32'h11); push_word(32'h22); push_word(32'h33);
      check("fill_three", 32'(fifo_fill), 32'd3);
      burst(10'h200, 2, 1'b0, '0);
      check_cap("stream_0", 0, 32'h11);
      check_cap("stream_1", 1, 32'h22);
      check_cap("stream_2", 2, 32'h33);
      check("fill_drained", 32'(fifo_fill), 32'd0);
      check("ready_drained", 32'(dev_ready), 32'd0);

      // Burst starting on an empty FIFO; the producer trickles words in.
      cap.delete();
      fork
         burst(10'h200, 3, 1'b0, '0);
         begin
            for (int k = 0; k < 4; k++) begin
               repeat (5) tick();
               push_word(32'h5000 + 32'(k));
            end
         end
      join
      for (int k = 0; k < 4; k++) check_cap("trickle", k, 32'h5000 + 32'(k));
      check("trickle_ovf", 32'(overflow), 32'd0);

      // Overfill, then read-to-clear through status word 0.
      for (int k = 0; k < 17; k++) push_word(32'h100 + 32'(k));
      check("full_fill", 32'(fifo_fill), 32'd16);
      check("full_ovf", 32'(overflow), 32'd1);
      cap.delete();
      burst(10'h000, 0, 1'b0, '0);
      check_cap("status0", 0, 32'h80000010);
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO: push alongside the first pop is kept and returned last.
      cap.delete();
      burst(10'h200, 16, 1'b1, 32'hCAFE);
      check_cap("full_first", 0, 32'h100);
      check_cap("full_16th", 15, 32'h10F);
      check_cap("full_last", 16, 32'hCAFE);
      check("full_push_ovf", 32'(overflow), 32'd0);
      check("full_push_fill", 32'(fifo_fill), 32'd0);

      // Reset in the middle of a stream burst.
      for (int k = 0; k < 5; k++) push_word(32'h700 + 32'(k));
      pre_araddr = 10'h200; start_burst = 1'b1;
      tick();
      start_burst = 1'b0; bram_raddr = 10'h200; bram_ren = 1'b1;
      tick();
      bram_ren = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_fill", 32'(fifo_fill), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_rdata", bram_rdata, 32'd0);
      check("rst_ready", 32'(dev_ready), 32'd1);
      tick();

      // Random traffic, alternating light and heavy producer epochs.
      for (int i = 0; i < 2000; i++) begin
         p_we        = ((i / 250) % 2 == 0) ? 3 : 1;
         s_we        = ($urandom_range(0, p_we) == 0);
         s_data      = $urandom;
         start_burst = ($urandom_range(0, 15) == 0);
         pre_araddr  = AB'($urandom);
         bram_raddr  = AB'($urandom);
         bram_ren    = dev_ready ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
         bram_regen  = ($urandom_range(0, 3) != 0);
         rst         = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 31) == 0) status_in[$urandom_range(0, 7)*32 +: 32] = $urandom;
         tick();
      end
      rst = 1'b0; s_we = 1'b0; bram_ren = 1'b0; start_burst = 1'b0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
